// File: rtl/eth_pause_req_gen.sv
// MAC flow-control sideband generator: link pause XOFF/XON with periodic XOFF refresh,
// plus per-priority PFC requests with a minimum hold time. Sideband = {pause_xoff, pause_xon, pfc_xoff[7:0]}.
module eth_pause_req_gen #(
    parameter int FILL_W         = 12,
    parameter int XOFF_THRESH    = 768,
    parameter int XON_THRESH     = 256,
    parameter int REFRESH_CYCLES = 4096,
    parameter int PFC_HOLD       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [FILL_W-1:0] rx_fill,
    input  logic [7:0]        pfc_req,
    output logic [9:0]        sb_to_mac,
    output logic              xoff_active,
    output logic [15:0]       xoff_sent_cnt
);
    localparam int RC_W = $clog2(REFRESH_CYCLES);
    localparam int HC_W = $clog2(PFC_HOLD + 1);
    localparam logic [FILL_W-1:0] XOFF_LVL     = FILL_W'(XOFF_THRESH);
    localparam logic [FILL_W-1:0] XON_LVL      = FILL_W'(XON_THRESH);
    localparam logic [RC_W-1:0]   REFRESH_LOAD = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [HC_W-1:0]   HOLD_LOAD    = HC_W'(PFC_HOLD - 1);

    if (XON_THRESH >= XOFF_THRESH) begin : g_bad_thresh
        $error("eth_pause_req_gen: XON_THRESH must be below XOFF_THRESH");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("eth_pause_req_gen: REFRESH_CYCLES must be at least 2");
    end
    if (PFC_HOLD < 1) begin : g_bad_hold
        $error("eth_pause_req_gen: PFC_HOLD must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SEND_XOFF, PAUSED, SEND_XON} state_e;

    state_e             state_q, state_d;
    logic [RC_W-1:0]    refresh_q, refresh_d;
    logic [15:0]        sent_q, sent_d;
    logic               pause_xoff_q, pause_xoff_d;
    logic               pause_xon_q, pause_xon_d;
    logic               xoff_active_q, xoff_active_d;
    logic [7:0]         pfc_xoff_q, pfc_xoff_d;
    logic [7:0]         req_q;
    logic [7:0][HC_W-1:0] hc_q, hc_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            refresh_q     <= '0;
            sent_q        <= '0;
            pause_xoff_q  <= 1'b0;
            pause_xon_q   <= 1'b0;
            xoff_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            refresh_q     <= refresh_d;
            sent_q        <= sent_d;
            pause_xoff_q  <= pause_xoff_d;
            pause_xon_q   <= pause_xon_d;
            xoff_active_q <= xoff_active_d;
        end
    end

    // The refresh counter is loaded on entry to SEND_XOFF and counts down through
    // SEND_XOFF and PAUSED, so consecutive XOFF pulses are exactly REFRESH_CYCLES apart.
    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q;
        sent_d    = sent_q;
        case (state_q)
            IDLE: begin
                if (enable && (rx_fill >= XOFF_LVL)) state_d = SEND_XOFF;
            end
            SEND_XOFF: begin
                state_d   = PAUSED;
                refresh_d = refresh_q - 1'b1;
            end
            PAUSED: begin
                if (!enable || (rx_fill <= XON_LVL)) state_d = SEND_XON;
                else if (refresh_q == '0)            state_d = SEND_XOFF;
                else                                 refresh_d = refresh_q - 1'b1;
            end
            SEND_XON: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (state_d == SEND_XOFF) begin
            refresh_d = REFRESH_LOAD;
            sent_d    = sat_inc(sent_q);
        end
        if (state_d == SEND_XON) refresh_d = '0;
    end

    always_comb begin
        pause_xoff_d  = (state_d == SEND_XOFF);
        pause_xon_d   = (state_d == SEND_XON);
        xoff_active_d = (state_d == SEND_XOFF) || (state_d == PAUSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfc_xoff_q <= '0;
            hc_q       <= '0;
            req_q      <= '0;
        end else begin
            pfc_xoff_q <= pfc_xoff_d;
            hc_q       <= hc_d;
            req_q      <= pfc_req;
        end
    end

    // A bit is set only by a fresh rising request; re-assertion during the hold does not reload it.
    always_comb begin
        pfc_xoff_d = pfc_xoff_q;
        hc_d       = hc_q;
        for (int i = 0; i < 8; i++) begin
            if (!enable) begin
                pfc_xoff_d[i] = 1'b0;
                hc_d[i]       = '0;
            end else if (!pfc_xoff_q[i]) begin
                if (pfc_req[i] && !req_q[i]) begin
                    pfc_xoff_d[i] = 1'b1;
                    hc_d[i]       = HOLD_LOAD;
                end
            end else if ((hc_q[i] == '0) && !pfc_req[i]) begin
                pfc_xoff_d[i] = 1'b0;
            end else if (hc_q[i] != '0) begin
                hc_d[i] = hc_q[i] - 1'b1;
            end
        end
    end

    assign sb_to_mac     = {pause_xoff_q, pause_xon_q, pfc_xoff_q};
    assign xoff_active   = xoff_active_q;
    assign xoff_sent_cnt = sent_q;

endmodule

// File: tb/tb_eth_pause_req_gen.sv
// Bench for eth_pause_req_gen: directed scenarios plus random traffic against an
// event-level model (pulse ages and per-priority on-time counts).
module tb_eth_pause_req_gen;
    localparam int R    = 4096;
    localparam int HOLD = 64;
    localparam int XOFF = 768;
    localparam int XON  = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] rx_fill = '0;
    logic [7:0]  pfc_req = '0;
    logic [9:0]  sb_to_mac;
    logic        xoff_active;
    logic [15:0] xoff_sent_cnt;

    int total = 0;
    int bad   = 0;

    bit       m_xoff, m_xon, m_paused;
    int       m_age, m_cnt;
    bit [7:0] m_pfc, m_prev;
    int       m_on [8];

    int cyc = 0, n_xoff = 0, n_xon = 0, last_xoff = -1, last_gap = 0;

    eth_pause_req_gen #(
        .FILL_W(12), .XOFF_THRESH(XOFF), .XON_THRESH(XON),
        .REFRESH_CYCLES(R), .PFC_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rx_fill(rx_fill),
        .pfc_req(pfc_req), .sb_to_mac(sb_to_mac), .xoff_active(xoff_active),
        .xoff_sent_cnt(xoff_sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_xoff = 0; m_xon = 0; m_paused = 0; m_age = 0; m_cnt = 0;
        m_pfc = '0; m_prev = '0;
        for (int i = 0; i < 8; i++) m_on[i] = 0;
    endtask

    // Link: pulses are REFRESH apart while congested; XON ends a pause; after XON one idle cycle.
    task automatic model_step(input bit en, input logic [11:0] fill, input logic [7:0] req);
        bit nx_xoff, nx_xon, nx_paused;
        nx_xoff = 0; nx_xon = 0; nx_paused = m_paused;
        if (m_xon) begin
            nx_paused = 0;
        end else if (!m_paused) begin
            if (en && fill >= XOFF) begin
                nx_xoff = 1; nx_paused = 1; m_age = 0;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (m_xoff) begin
            m_age++;
        end else if (!en || fill <= XON) begin
            nx_xon = 1; nx_paused = 0;
        end else if (m_age + 1 == R) begin
            nx_xoff = 1; m_age = 0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_age++;
        end
        m_xoff = nx_xoff; m_xon = nx_xon; m_paused = nx_paused;
        for (int i = 0; i < 8; i++) begin
            if (!en) begin
                m_pfc[i] = 0; m_on[i] = 0;
            end else if (!m_pfc[i]) begin
                if (req[i] && !m_prev[i]) begin m_pfc[i] = 1; m_on[i] = 1; end
            end else if (m_on[i] >= HOLD && !req[i]) begin
                m_pfc[i] = 0; m_on[i] = 0;
            end else begin
                m_on[i]++;
            end
        end
        m_prev = req;
    endtask

    task automatic check_all();
        chk("pause_xoff", 32'(sb_to_mac[9]), 32'(m_xoff));
        chk("pause_xon", 32'(sb_to_mac[8]), 32'(m_xon));
        chk("pfc_xoff", 32'(sb_to_mac[7:0]), 32'(m_pfc));
        chk("xoff_active", 32'(xoff_active), 32'(m_paused));
        chk("xoff_sent_cnt", 32'(xoff_sent_cnt), 32'(m_cnt));
        chk("pulse_excl", 32'(sb_to_mac[9] & sb_to_mac[8]), 32'd0);
    endtask

    task automatic step(input bit en, input logic [11:0] fill, input logic [7:0] req);
        enable = en; rx_fill = fill; pfc_req = req;
        @(posedge clk);
        model_step(en, fill, req);
        @(negedge clk);
        cyc++;
        check_all();
        if (sb_to_mac[9]) begin
            if (last_xoff >= 0) last_gap = cyc - last_xoff;
            last_xoff = cyc;
            n_xoff++;
        end
        if (sb_to_mac[8]) n_xon++;
    endtask

    initial begin
        int hi3, hi5, region;
        bit en;
        logic [11:0] f;
        logic [7:0] req;

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_sb", 32'(sb_to_mac), 32'd0);
        chk("reset_active", 32'(xoff_active), 32'd0);
        chk("reset_cnt", 32'(xoff_sent_cnt), 32'd0);
        rst_n = 1'b1;

        // Ramp to 800 and hold: one XOFF, then refreshes
        n_xoff = 0;
        for (int v = 0; v <= 800; v += 16) step(1, 12'(v), 8'h00);
        chk("ramp_pulses", 32'(n_xoff), 32'd1);
        chk("ramp_active", 32'(xoff_active), 32'd1);
        chk("ramp_cnt", 32'(xoff_sent_cnt), 32'd1);
        n_xoff = 0;
        for (int k = 0; k < 3 * R; k++) step(1, 12'd800, 8'h00);
        chk("refresh_pulses", 32'(n_xoff), 32'd3);
        chk("refresh_gap", 32'(last_gap), 32'(R));
        chk("refresh_cnt", 32'(xoff_sent_cnt), 32'd4);

        // Hysteresis band, then XON at the low watermark
        n_xon = 0;
        for (int k = 0; k < 50; k++) step(1, 12'd500, 8'h00);
        chk("band_xon", 32'(n_xon), 32'd0);
        chk("band_active", 32'(xoff_active), 32'd1);
        step(1, 12'd256, 8'h00);
        chk("xon_pulse", 32'(sb_to_mac[8]), 32'd1);
        chk("xon_inactive", 32'(xoff_active), 32'd0);
        step(1, 12'd256, 8'h00);
        chk("xon_single", 32'(sb_to_mac[8]), 32'd0);

        // Refresh expiry coinciding with low watermark
        step(1, 12'd800, 8'h00);
        for (int k = 0; k < R + 8; k++) begin
            if (m_paused && !m_xoff && m_age == R - 1) break;
            step(1, 12'd800, 8'h00);
        end
        step(1, 12'd256, 8'h00);
        chk("coin_xon", 32'(sb_to_mac[8]), 32'd1);
        chk("coin_no_xoff", 32'(sb_to_mac[9]), 32'd0);
        step(1, 12'd256, 8'h00);
        chk("coin_no_xoff_next", 32'(sb_to_mac[9]), 32'd0);

        // PFC minimum hold and long request
        hi3 = 0;
        for (int k = 0; k < 90; k++) begin
            step(1, 12'd100, (k < 5) ? 8'h08 : 8'h00);
            if (sb_to_mac[3]) hi3++;
        end
        chk("pfc3_len", 32'(hi3), 32'(HOLD));
        hi5 = 0;
        for (int k = 0; k < 130; k++) begin
            step(1, 12'd100, (k < 100) ? 8'h20 : 8'h00);
            if (sb_to_mac[5]) hi5++;
        end
        chk("pfc5_len", 32'(hi5), 32'd100);

        // Reset while paused: outputs drop at once, no XON afterwards
        for (int k = 0; k < 4; k++) step(1, 12'd800, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sb", 32'(sb_to_mac), 32'd0);
        chk("rst_mid_active", 32'(xoff_active), 32'd0);
        chk("rst_mid_cnt", 32'(xoff_sent_cnt), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_xon = 0;
        for (int k = 0; k < 10; k++) step(1, 12'd500, 8'h00);
        chk("rst_no_xon", 32'(n_xon), 32'd0);

        // Disable while paused: one XON, PFC cleared, then idle
        for (int k = 0; k < 4; k++) step(1, 12'd800, (k < 1) ? 8'h00 : 8'h81);
        step(0, 12'd800, 8'h81);
        chk("dis_xon", 32'(sb_to_mac[8]), 32'd1);
        chk("dis_pfc", 32'(sb_to_mac[7:0]), 32'd0);
        step(0, 12'd800, 8'h81);
        chk("dis_idle_xoff", 32'(sb_to_mac[9]), 32'd0);
        chk("dis_idle_active", 32'(xoff_active), 32'd0);

        // Random traffic
        region = 2; en = 1; req = '0;
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(63) == 0) region = int'($urandom_range(2));
            case (region)
                0:       f = 12'($urandom_range(256));
                1:       f = 12'($urandom_range(767, 257));
                default: f = 12'($urandom_range(4095, 768));
            endcase
            if ($urandom_range(511) == 0) en = !en;
            for (int b = 0; b < 8; b++) if ($urandom_range(39) == 0) req[b] = !req[b];
            step(en, f, req);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
